// File: rtl/rf_write_sched.sv
// rtl/rf_write_sched.sv - write-port arbiter and pending-write scoreboard for the 32x64 register file
module rf_write_sched #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int DW       = 64,
    parameter int ZERO_REG = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_reg,
    input  logic [DW-1:0]   a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_reg,
    input  logic [DW-1:0]   b_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_reg,
    input  logic [AW-1:0]   rd1_reg,
    input  logic [AW-1:0]   rd2_reg,
    output logic            rd1_busy,
    output logic            rd2_busy,
    output logic            RegWrite,
    output logic [AW-1:0]   WriteRegister,
    output logic [DW-1:0]   WriteData,
    output logic [NREG-1:0] pending
);

    typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_t;

    localparam logic [AW-1:0] ZREG = AW'(ZERO_REG);

    ptr_t            rrptr;
    logic            a_gnt;
    logic            b_gnt;
    logic            a_wr;
    logic            b_wr;
    logic [NREG-1:0] pending_nxt;

    // Grants are gated by reset so a request in the reset cycle is simply dropped.
    always_comb begin
        a_gnt = !rst && a_valid && (!b_valid || rrptr == PTR_A);
        b_gnt = !rst && b_valid && (!a_valid || rrptr == PTR_B);
        a_wr  = a_gnt && (a_reg != ZREG);
        b_wr  = b_gnt && (b_reg != ZREG);
    end

    assign a_ready = a_gnt;
    assign b_ready = b_gnt;

    // Issue is applied after retirement so a same-cycle set wins over the clear.
    always_comb begin
        pending_nxt = pending;
        if (RegWrite)
            pending_nxt[WriteRegister] = 1'b0;
        if (iss_en && iss_reg != ZREG)
            pending_nxt[iss_reg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            pending       <= '0;
            rrptr         <= PTR_A;
        end else begin
            RegWrite <= a_wr || b_wr;
            pending  <= pending_nxt;
            if (a_wr) begin
                WriteRegister <= a_reg;
                WriteData     <= a_data;
            end else if (b_wr) begin
                WriteRegister <= b_reg;
                WriteData     <= b_data;
            end
            if (a_gnt)
                rrptr <= PTR_B;
            else if (b_gnt)
                rrptr <= PTR_A;
        end
    end

    assign rd1_busy = pending[rd1_reg] && (rd1_reg != ZREG);
    assign rd2_busy = pending[rd2_reg] && (rd2_reg != ZREG);

endmodule

// File: tb/tb_rf_write_sched.sv
// tb/tb_rf_write_sched.sv - randomized reference-model bench for rf_write_sched
module tb_rf_write_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_reg, b_reg, iss_reg, rd1_reg, rd2_reg, WriteRegister;
    logic [63:0] a_data, b_data, WriteData;
    logic        iss_en, rd1_busy, rd2_busy, RegWrite;
    logic [31:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    rf_write_sched dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .iss_en(iss_en), .iss_reg(iss_reg),
        .rd1_reg(rd1_reg), .rd2_reg(rd2_reg),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // External register file, captured on the falling edge as the real one does.
    logic [63:0] tb_rf [32];
    always @(negedge clk)
        if (RegWrite === 1'b1 && WriteRegister != 5'd31)
            tb_rf[WriteRegister] <= WriteData;

    function automatic logic [63:0] rf_rd(input logic [4:0] r);
        return (r == 5'd31) ? 64'd0 : tb_rf[r];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who wins, what gets written next cycle, what is outstanding.
    bit          m_live = 0;
    bit          m_turn_a;
    bit          m_regwrite;
    logic [4:0]  m_wreg;
    logic [63:0] m_wdata;
    bit [31:0]   m_pend;
    logic [63:0] m_rf [32];
    bit          ea, eb, e_busy1, e_busy2;

    always @(negedge clk) begin
        ea = !rst && a_valid && (!b_valid || m_turn_a);
        eb = !rst && b_valid && (!a_valid || !m_turn_a);
        e_busy1 = m_pend[rd1_reg] && rd1_reg != 5'd31;
        e_busy2 = m_pend[rd2_reg] && rd2_reg != 5'd31;
        if (m_live) begin
            chk("a_ready", a_ready, ea);
            chk("b_ready", b_ready, eb);
            chk("RegWrite", RegWrite, m_regwrite);
            chk("WriteRegister", WriteRegister, m_wreg);
            chk("WriteData", WriteData, m_wdata);
            chk("pending", pending, m_pend);
            chk("rd1_busy", rd1_busy, e_busy1);
            chk("rd2_busy", rd2_busy, e_busy2);
            if (!e_busy1) chk("rd1_data", rf_rd(rd1_reg), m_rf[rd1_reg]);
            if (!e_busy2) chk("rd2_data", rf_rd(rd2_reg), m_rf[rd2_reg]);
        end
        if (m_regwrite) m_rf[m_wreg] = m_wdata;
        if (rst) begin
            m_live = 1; m_turn_a = 1; m_regwrite = 0;
            m_wreg = 0; m_wdata = 0; m_pend = 0;
        end else begin
            if (m_regwrite) m_pend[m_wreg] = 0;
            if (iss_en && iss_reg != 5'd31) m_pend[iss_reg] = 1;
            m_regwrite = 0;
            if (ea) begin
                m_turn_a = 0;
                if (a_reg != 5'd31) begin m_regwrite = 1; m_wreg = a_reg; m_wdata = a_data; end
            end else if (eb) begin
                m_turn_a = 1;
                if (b_reg != 5'd31) begin m_regwrite = 1; m_wreg = b_reg; m_wdata = b_data; end
            end
        end
    end

    task automatic cyc; @(posedge clk); #1; endtask
    task automatic smp; @(negedge clk); endtask

    logic [4:0] exp_wr [4];
    bit a_took, b_took;

    initial begin
        for (int i = 0; i < 32; i++) begin tb_rf[i] = 64'd0; m_rf[i] = 64'd0; end
        exp_wr[0] = 5'd3; exp_wr[1] = 5'd7; exp_wr[2] = 5'd3; exp_wr[3] = 5'd7;
        rst = 1; a_valid = 1; b_valid = 1; a_reg = 5'd3; b_reg = 5'd7;
        a_data = 64'hA0A0; b_data = 64'hB0B0; iss_en = 0; iss_reg = 0; rd1_reg = 0; rd2_reg = 0;

        // Reset with both requesters active
        repeat (3) begin
            smp;
            chk("rst_a_ready", a_ready, 1'b0);
            chk("rst_b_ready", b_ready, 1'b0);
        end
        cyc; rst = 0; a_valid = 0; b_valid = 0;
        smp;
        chk("rst_RegWrite", RegWrite, 1'b0);
        chk("rst_pending", pending, 32'd0);

        // Contention: A,B,A,B
        for (int i = 0; i < 5; i++) begin
            cyc; a_valid = (i < 4); b_valid = (i < 4);
            smp;
            if (i < 4) begin
                chk("cont_a_ready", a_ready, (i % 2 == 0));
                chk("cont_b_ready", b_ready, (i % 2 == 1));
            end
            if (i >= 1) begin
                chk("cont_RegWrite", RegWrite, 1'b1);
                chk("cont_WriteRegister", WriteRegister, exp_wr[i-1]);
                chk("cont_WriteData", WriteData, (i % 2 == 1) ? 64'hA0A0 : 64'hB0B0);
            end
        end

        // Zero register: accepted, pointer advances, nothing written
        cyc; a_valid = 1; a_reg = 5'd31; a_data = 64'hDEAD; b_valid = 0;
        smp; chk("zero_a_ready", a_ready, 1'b1);
        cyc; b_valid = 1; b_reg = 5'd7; b_data = 64'hB1B1;
        smp;
        chk("zero_RegWrite", RegWrite, 1'b0);
        chk("zero_ptr_b_ready", b_ready, 1'b1);
        chk("zero_ptr_a_ready", a_ready, 1'b0);
        cyc; b_valid = 0;
        smp;
        chk("zero_a_ready2", a_ready, 1'b1);
        chk("zero_b_write", WriteRegister, 5'd7);
        cyc; a_valid = 0;
        smp;
        chk("zero_RegWrite2", RegWrite, 1'b0);
        chk("zero_read_x31", rf_rd(5'd31), 64'd0);

        // Scoreboard RAW tracking on register 5
        cyc; iss_en = 1; iss_reg = 5'd5; rd1_reg = 5'd5;
        smp; chk("sb_busy_before", rd1_busy, 1'b0);
        cyc; iss_en = 0; a_valid = 1; a_reg = 5'd5; a_data = 64'h1234_5678_9ABC_DEF0;
        smp;
        chk("sb_busy_pending", rd1_busy, 1'b1);
        chk("sb_a_ready", a_ready, 1'b1);
        cyc; a_valid = 0;
        smp;
        chk("sb_wr_reg", WriteRegister, 5'd5);
        chk("sb_busy_wrcycle", rd1_busy, 1'b1);
        cyc;
        smp;
        chk("sb_busy_after", rd1_busy, 1'b0);
        chk("sb_read", rf_rd(5'd5), 64'h1234_5678_9ABC_DEF0);

        // Set wins over clear on register 9
        cyc; iss_en = 1; iss_reg = 5'd9; rd2_reg = 5'd9;
        cyc; iss_en = 0; a_valid = 1; a_reg = 5'd9; a_data = 64'h99;
        smp; chk("sw_busy", rd2_busy, 1'b1);
        cyc; a_valid = 0; iss_en = 1; iss_reg = 5'd9;
        smp; chk("sw_wr_reg", WriteRegister, 5'd9);
        cyc; iss_en = 0;
        smp;
        chk("sw_pending9", pending[9], 1'b1);
        chk("sw_busy_after", rd2_busy, 1'b1);

        // Random traffic against the model, with occasional mid-run resets
        a_took = 0; b_took = 0;
        for (int n = 0; n < 2000; n++) begin
            cyc;
            if (rst || !a_valid || a_took) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_reg   = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                a_data  = {$urandom, $urandom};
            end
            if (rst || !b_valid || b_took) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_reg   = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                b_data  = {$urandom, $urandom};
            end
            rst     = ($urandom_range(0, 99) == 0);
            iss_en  = ($urandom_range(0, 9) < 3);
            iss_reg = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'd31;
            rd1_reg = 5'($urandom_range(0, 31));
            rd2_reg = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            smp;
            a_took = a_valid && a_ready;
            b_took = b_valid && b_ready;
        end

        cyc; rst = 0; a_valid = 0; b_valid = 0; iss_en = 0;
        repeat (3) cyc;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
